// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the Cardinal CMP node NIC: register map, packet width
// and the position of the virtual-channel bit inside a packet.
package cardinal_nic_pkg;
  localparam int PKT_W  = 64;
  localparam int VC_BIT = 0;

  localparam logic [1:0] NIC_IN_BUF   = 2'b00;
  localparam logic [1:0] NIC_IN_STAT  = 2'b01;
  localparam logic [1:0] NIC_OUT_BUF  = 2'b10;
  localparam logic [1:0] NIC_OUT_STAT = 2'b11;
endpackage

// File: rtl/nic_channel_buf.sv
// One-entry channel buffer. Callers only load when empty and clear when full,
// so load and clear never overlap; clearing keeps the data (stale reads allowed).
module nic_channel_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         clr_i,
  input  logic [0:W-1] d_i,
  output logic         full_o,
  output logic [0:W-1] q_o
);
  logic [0:W-1] data_q, data_d;
  logic         full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = d_i;
      full_d = 1'b1;
    end else if (clr_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign full_o = full_q;
  assign q_o    = data_q;
endmodule

// File: rtl/cardinal_net_iface.sv
// Network-side NIC responder: decodes CPU register accesses and moves 64-bit
// packets between the router port and one-entry input/output buffers.
module cardinal_net_iface
  import cardinal_nic_pkg::*;
#(
  parameter int DATA_WIDTH = PKT_W,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [0:ADDR_WIDTH-1] addr,
  input  logic [0:DATA_WIDTH-1] d_in,
  output logic [0:DATA_WIDTH-1] d_out,
  input  logic                  nicEn,
  input  logic                  nicWrEn,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [0:DATA_WIDTH-1] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [0:DATA_WIDTH-1] net_do,
  input  logic                  net_polarity
);
  logic                  rd, wr;
  logic                  in_full, out_full;
  logic                  in_load, in_clr, out_load;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;

  assign rd = nicEn & ~nicWrEn;
  assign wr = nicEn & nicWrEn;

  // All decisions below look only at pre-edge flags, so a write racing a send
  // sees out_full=1 and is dropped.
  assign net_ri   = ~in_full & ~reset;
  assign in_load  = net_si & net_ri;
  assign in_clr   = rd & (addr == NIC_IN_BUF) & in_full;
  assign out_load = wr & (addr == NIC_OUT_BUF) & ~out_full;
  assign net_so   = out_full & net_ro & (out_buf[VC_BIT] == net_polarity) & ~reset;
  assign net_do   = reset ? '0 : out_buf;

  nic_channel_buf #(.W(DATA_WIDTH)) u_in_buf (
    .clk    (clk),
    .reset  (reset),
    .load_i (in_load),
    .clr_i  (in_clr),
    .d_i    (net_di),
    .full_o (in_full),
    .q_o    (in_buf)
  );

  nic_channel_buf #(.W(DATA_WIDTH)) u_out_buf (
    .clk    (clk),
    .reset  (reset),
    .load_i (out_load),
    .clr_i  (net_so),
    .d_i    (d_in),
    .full_o (out_full),
    .q_o    (out_buf)
  );

  // Status flags sit in bit DATA_WIDTH-1 (the LSB of the big-endian word).
  always_comb begin
    d_out = '0;
    if (rd && !reset) begin
      case (addr)
        NIC_IN_BUF:   d_out = in_buf;
        NIC_IN_STAT:  d_out = {{(DATA_WIDTH-1){1'b0}}, in_full};
        NIC_OUT_BUF:  d_out = out_buf;
        NIC_OUT_STAT: d_out = {{(DATA_WIDTH-1){1'b0}}, out_full};
        default:      d_out = '0;
      endcase
    end
  end
endmodule

// File: doc/cardinal_net_iface.md
# cardinal_net_iface

Network-side responder for the per-node processor/NIC register interface in the Cardinal CMP: it answers the CPU's `nicEn`/`nicWrEn` register accesses and exchanges 64-bit packets with the node's ring router through one-entry input and output channel buffers. There is one instance per node, between the node's CPU and its router port. It is the counterpart of the CPU-side NIC access path, the same way the data memory is the counterpart of the CPU's `memEn`/`memWrEn` path.

## Interface
Parameters:
- `DATA_WIDTH`, 64, packet and register width.
- `ADDR_WIDTH`, 2, register address width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `d_in`  in  [0:63]  write data from the CPU.
- `d_out`  out  [0:63]  read data to the CPU.
- `nicEn`  in  1  access enable.
- `nicWrEn`  in  1  write enable; qualified by `nicEn`.
- `net_si`  in  1  router presents a packet.
- `net_ri`  out  1  NIC can accept a packet.
- `net_di`  in  [0:63]  packet from the router.
- `net_so`  out  1  NIC sends a packet this cycle.
- `net_ro`  in  1  router can accept a packet.
- `net_do`  out  [0:63]  packet to the router.
- `net_polarity`  in  1  router's current VC polarity.

## Operation
- **State**
  - `in_buf`[0:63] with `in_full`.
  - `out_buf`[0:63] with `out_full`.
- **CPU read** (`nicEn`=1, `nicWrEn`=0). `d_out` is combinational:
  - addr 00: `in_buf`.
  - addr 01: {63'b0, `in_full`}; the flag is in bit 63.
  - addr 10: `out_buf`.
  - addr 11: {63'b0, `out_full`}.
  - Otherwise, and during any write, `d_out` = 0.
- **Input buffer drain.** A read of addr 00 while `in_full`=1 clears `in_full` at the next edge. Reading addr 00 while empty returns stale `in_buf` and changes no state.
- **CPU write** (`nicEn`=1, `nicWrEn`=1).
  - addr 10 with `out_full`=0: `out_buf` ← `d_in` and `out_full` ← 1.
  - addr 10 with `out_full`=1: the write is silently dropped.
  - Writes to 00, 01 or 11 are ignored.
- **Network input.**
  - `net_ri` = ~`in_full` & ~`reset`.
  - If `net_si` & `net_ri` at an edge: `in_buf` ← `net_di` and `in_full` ← 1.
  - `net_si` while `net_ri`=0 is ignored; the router holds the packet.
- **Network output.**
  - `net_so` = `out_full` & `net_ro` & (`out_buf`[0] == `net_polarity`). Bit 0 is the VC bit.
  - `net_do` = `out_buf`.
  - When `net_so`=1 at an edge, `out_full` ← 0.
- **Simultaneous events.**
  - All decisions use pre-edge flag values.
  - A CPU write to addr 10 in the same cycle as a send is dropped, because `out_full` was 1.
  - A CPU drain of addr 00 and an arriving packet cannot coincide, because `net_ri`=0 while full.
- **Reset.** Clears `in_buf`, `out_buf`, `in_full` and `out_full`. Therefore `d_out`=0, `net_so`=0, `net_do`=0 and `net_ri`=0 while reset is high. Reset asserted mid-transfer discards both buffers; no packet is emitted.

## Timing
- CPU read data: 0-cycle latency (combinational from `addr`/`nicEn`).
- Status flags change 1 cycle after the causing edge.
- Router packet to CPU-visible `in_full`: 1 cycle.
- CPU write to `net_so` eligibility: 1 cycle, then gated by `net_ro` and polarity.
- A packet whose VC bit mismatches `net_polarity` waits at least 1 cycle. The polarity toggles every cycle, so worst-case wait is 1 cycle if `net_ro`=1.
- Throughput: 1 packet per 2 cycles per direction, bounded by the CPU drain/refill cycle.

## Structure
- Package `cardinal_nic_pkg`:
  - register address constants `NIC_IN_BUF`=2'b00, `NIC_IN_STAT`=2'b01, `NIC_OUT_BUF`=2'b10, `NIC_OUT_STAT`=2'b11.
  - `VC_BIT`=0.
  - `PKT_W`=64.
- Sub-module `nic_channel_buf`: one-entry buffer with load/clear/full, instantiated twice (input and output).
- Top level: register decode, `d_out` mux, handshake glue.

## Test plan
- **Reset:** hold `reset` 3 cycles with `net_si`=1 → `net_ri`=0, `net_so`=0, `d_out`=0 throughout; after release, `net_ri`=1.
- **Receive:** `net_si`=1, `net_di`=64'hA5A5_0000_1234_5678 → next cycle `net_ri`=0; read 01 → 64'h1; read 00 → 64'hA5A5_0000_1234_5678; next cycle `net_ri`=1.
- **Back-pressure:** with `in_full`=1, present 64'hDEAD for 5 cycles → `in_buf` is unchanged; the packet is captured 1 cycle after the CPU drains.
- **Send with polarity:**
  - write 10 with 64'h8000_0000_0000_00FF (VC=1), `net_ro`=1.
  - `net_so` is asserted only in the cycle where `net_polarity`=1, with `net_do`=64'h8000_0000_0000_00FF.
  - read 11 → 0 afterward.
- **Full drop and stall:**
  - with `out_full`=1 and `net_ro`=0, write 64'h1111 → read 10 returns the original packet.
  - raise `net_ro`; write 64'h2222 in the send cycle → dropped, status 0 after.
- **Mid-operation reset:** both buffers full, assert reset 1 cycle → both status reads 0, no `net_so` pulse, `net_ri`=1 after release.
